// File: rtl/bmi_weight_calc_pkg.sv
// bmi_weight_calc_pkg: shared widths, FSM state encoding and saturation value for the BMI weight calculator.
package bmi_weight_calc_pkg;
  localparam int DATA_W = 8;
  localparam int SQ_W = 2 * DATA_W;
  localparam int ACC_W = 3 * DATA_W;
  localparam logic [7:0] SAT_MAX = 8'hFF;
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_SQUARE = 2'd1;
  localparam state_t S_SCALE = 2'd2;
  localparam state_t S_DONE = 2'd3;
endpackage

// File: rtl/bmi_weight_calc_seq_shift_add_mult.sv
// seq_shift_add_mult: iterative shift-add multiplier, one multiplier bit per step, LSB first.
module seq_shift_add_mult #(
  parameter int MCAND_W = 16,
  parameter int MPLR_W = 8,
  parameter int PROD_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [MCAND_W-1:0] mcand,
  input  logic [MPLR_W-1:0] mplier,
  output logic [PROD_W-1:0] prod_nxt,
  output logic              last
);
  localparam int CNT_W = $clog2(MPLR_W);
  logic [MCAND_W-1:0] mcand_q, mcand_d;
  logic [MPLR_W-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PROD_W-1:0] prod_q, prod_d;
  // prod_nxt is the product after the current step, so the owner can act on the final value at the last edge
  always_comb begin
    prod_nxt = prod_q + (mplier_q[cnt_q] ? (PROD_W'(mcand_q) << cnt_q) : '0);
    last = cnt_q == CNT_W'(MPLR_W - 1);
    mcand_d = load ? mcand : mcand_q;
    mplier_d = load ? mplier : mplier_q;
    cnt_d = load ? '0 : step ? cnt_q + 1'b1 : cnt_q;
    prod_d = load ? '0 : step ? prod_nxt : prod_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q <= '0;
      mplier_q <= '0;
      cnt_q <= '0;
      prod_q <= '0;
    end else begin
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q <= cnt_d;
      prod_q <= prod_d;
    end
  end
endmodule

// File: rtl/bmi_weight_calc.sv
// bmi_weight_calc: computes weight = category * height^2 in two 8-cycle shift-add phases, saturated to DATA_W bits.
module bmi_weight_calc #(
  parameter int DATA_W = bmi_weight_calc_pkg::DATA_W,
  parameter int SQ_W = bmi_weight_calc_pkg::SQ_W,
  parameter int ACC_W = bmi_weight_calc_pkg::ACC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              start,
  input  logic [DATA_W-1:0] height,
  input  logic [DATA_W-1:0] category,
  output logic [DATA_W-1:0] weight,
  output logic              overflow,
  output logic              busy,
  output logic              done
);
  import bmi_weight_calc_pkg::*;
  state_t state_q, state_d;
  logic [DATA_W-1:0] weight_q, weight_d, cat_q, cat_d;
  logic ov_q, ov_d, busy_q, busy_d, done_q, done_d;
  logic load, step, last;
  logic [SQ_W-1:0] mcand_in;
  logic [DATA_W-1:0] mplier_in;
  logic [ACC_W-1:0] prod_nxt;
  // one multiplier is reused: height*height first, then square*category
  seq_shift_add_mult #(.MCAND_W(SQ_W), .MPLR_W(DATA_W), .PROD_W(ACC_W)) u_mult (
    .clk(clk),
    .rst_n(rst_n),
    .load(load),
    .step(step),
    .mcand(mcand_in),
    .mplier(mplier_in),
    .prod_nxt(prod_nxt),
    .last(last)
  );
  always_comb begin
    state_d = state_q;
    weight_d = weight_q;
    ov_d = ov_q;
    busy_d = busy_q;
    done_d = 1'b0;
    cat_d = cat_q;
    load = 1'b0;
    step = 1'b0;
    mcand_in = SQ_W'(height);
    mplier_in = height;
    if (!enable) begin
      state_d = S_IDLE;
      weight_d = '0;
      ov_d = 1'b0;
      busy_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          state_d = S_SQUARE;
          busy_d = 1'b1;
          cat_d = category;
          load = 1'b1;
        end
        S_SQUARE: begin
          step = 1'b1;
          if (last) begin
            state_d = S_SCALE;
            load = 1'b1;
            mcand_in = prod_nxt[SQ_W-1:0];
            mplier_in = cat_q;
          end
        end
        S_SCALE: begin
          step = 1'b1;
          if (last) begin
            state_d = S_DONE;
            busy_d = 1'b0;
            done_d = 1'b1;
            ov_d = |prod_nxt[ACC_W-1:DATA_W];
            weight_d = ov_d ? {DATA_W{1'b1}} : prod_nxt[DATA_W-1:0];
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      weight_q <= '0;
      cat_q <= '0;
      ov_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      weight_q <= weight_d;
      cat_q <= cat_d;
      ov_q <= ov_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign weight = weight_q;
  assign overflow = ov_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_bmi_weight_calc.sv
// tb_bmi_weight_calc: directed and random operations against an arithmetic model of category*height^2 saturated to 8 bits.
module tb_bmi_weight_calc;
  logic clk = 1'b0;
  logic rst_n, enable, start;
  logic [7:0] height, category, weight;
  logic overflow, busy, done;
  int total = 0;
  int bad = 0;
  bmi_weight_calc dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .start(start),
    .height(height),
    .category(category),
    .weight(weight),
    .overflow(overflow),
    .busy(busy),
    .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  // mode: 0 plain, 1 extra start pulses and operand changes, 2 enable drop, 3 async reset mid-SCALE
  task automatic run_op(input logic [7:0] h, input logic [7:0] c, input int mode);
    int p;
    logic [7:0] ew, prev_w;
    logic eo;
    p = int'(h) * int'(h) * int'(c);
    eo = p > 255;
    ew = eo ? 8'hFF : 8'(p);
    prev_w = weight;
    @(negedge clk);
    height = h;
    category = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("busy_run", busy, 1);
      chk("done_early", done, 0);
      if (mode == 0) chk("weight_held", weight, prev_w);
      if (mode == 1) begin
        start = (i == 2 || i == 15);
        if (i == 4) begin
          height = ~h;
          category = ~c;
        end
      end
      if (mode == 2 && i == 7) begin
        enable = 1'b0;
        @(negedge clk);
        chk("en_busy", busy, 0);
        chk("en_weight", weight, 0);
        chk("en_ovf", overflow, 0);
        for (int j = 0; j < 18; j++) begin
          chk("en_no_done", done, 0);
          @(negedge clk);
        end
        enable = 1'b1;
        return;
      end
      if (mode == 3 && i == 11) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_weight", weight, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 6; j++) begin
          chk("rst_no_done", done, 0);
          @(negedge clk);
        end
        return;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_pulse", done, 1);
    chk("busy_end", busy, 0);
    chk("weight", weight, ew);
    chk("overflow", overflow, eo);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("done_once", done, 0);
      chk("weight_hold", weight, ew);
      chk("idle_busy", busy, 0);
    end
  endtask
  initial begin
    rst_n = 1'b0;
    enable = 1'b1;
    start = 1'b0;
    height = '0;
    category = '0;
    repeat (2) @(negedge clk);
    chk("reset_weight", weight, 0);
    chk("reset_ovf", overflow, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    start = 1'b1;
    @(negedge clk);
    chk("start_disabled", busy, 0);
    start = 1'b0;
    enable = 1'b1;
    run_op(8'd2, 8'd25, 0);
    run_op(8'd10, 8'd25, 0);
    run_op(8'd0, 8'd200, 0);
    run_op(8'd15, 8'd0, 0);
    run_op(8'd1, 8'd255, 0);
    run_op(8'd16, 8'd1, 0);
    run_op(8'd3, 8'd20, 1);
    run_op(8'd4, 8'd9, 2);
    run_op(8'd3, 8'd7, 0);
    run_op(8'd5, 8'd5, 3);
    run_op(8'd3, 8'd11, 0);
    for (int n = 0; n < 30; n++) begin
      logic [7:0] rh, rc;
      rh = (n % 3 == 0) ? 8'($urandom) : 8'($urandom_range(0, 20));
      rc = 8'($urandom);
      run_op(rh, rc, (n % 7 == 3) ? 1 : 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bmi_weight_calc.md
Name: bmi_weight_calc

Overview:
- Inverse of the BMI category block: given height and a target BMI category, computes the weight that produces it, weight = category * height^2.
- Sequential: two shift-add multiply phases with a start/done handshake, and the result saturated to 8 bits.
- Sits beside the BMI categoriser and feeds its weight input during closed-loop checks; it also serves the target-weight display path.

Parameters:
- DATA_W, 8, width of height, category and weight operands.
- SQ_W, 2*DATA_W, width of the height^2 intermediate.
- ACC_W, 3*DATA_W, width of the full product accumulator.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  block enable; low aborts and clears the result.
- start  input  1  request pulse; sampled in IDLE only.
- height  input  DATA_W  height operand; captured when start is accepted.
- category  input  DATA_W  target BMI category; captured when start is accepted.
- weight  output  DATA_W  saturated result; held until the next accepted start.
- overflow  output  1  product exceeded 2^DATA_W-1; held with weight.
- busy  output  1  high from the acceptance edge until DONE is entered.
- done  output  1  one-cycle pulse when weight/overflow are updated.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; weight=0, overflow=0, busy=0, done=0; internal operand, accumulator and counter registers cleared.
- FSM states: IDLE, SQUARE, SCALE, DONE.
- IDLE: on an edge with enable=1 and start=1, capture height and category, clear the accumulator and bit counter, set busy=1, go to SQUARE. start with enable=0 is ignored.
- SQUARE: 8 cycles, one height bit per cycle, LSB first.
  - If the bit is set, add height shifted left by the bit index into the 16-bit square accumulator.
  - After bit 7, go to SCALE with the counter reset.
- SCALE: 8 cycles, one category bit per cycle.
  - If the bit is set, add the square shifted left by the bit index into the 24-bit accumulator.
  - After bit 7, go to DONE.
- DONE entry edge (edge k+16, where k is the acceptance edge):
  - If accumulator[23:8] != 0: weight=8'hFF, overflow=1.
  - Else: weight=accumulator[7:0], overflow=0.
  - busy=0, done=1 for exactly one cycle; next edge returns to IDLE.
- Fixed latency: done visible after edge k+16 regardless of operand values; no early termination on zero operands.
- start while busy (SQUARE/SCALE/DONE) is ignored; there is no queuing.
- start high in the same cycle that DONE returns to IDLE is not accepted; it is accepted on the next edge in IDLE if still high.
- enable=0 in any state: next edge forces IDLE, weight=0, overflow=0, busy=0, done=0; an in-flight operation is discarded.
- Operands changing after acceptance have no effect on the in-flight result.
- All arithmetic is unsigned. Intermediate widths are sized so no internal wrap-around occurs; saturation happens only at the output.
- Reset asserted mid-operation: immediate return to reset values and no done pulse.

Decomposition:
- Shared package holds:
  - DATA_W/SQ_W/ACC_W constants.
  - FSM state typedef, 2-bit encoding: IDLE=0, SQUARE=1, SCALE=2, DONE=3.
  - SAT_MAX constant 8'hFF.
- One sub-module is natural: seq_shift_add_mult, a parameterised iterative multiplier stepping one multiplier bit per cycle with a load/step/last interface.
  - Instantiated once and time-shared between the SQUARE and SCALE phases under FSM control; alternatively the FSM may sequence two widths of the same module.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset then height=2, category=25, start pulse at edge k -> busy=1 for k..k+15, done=1 only after edge k+16, weight=100, overflow=0.
- height=10, category=25 -> product 2500 -> weight=255, overflow=1, done at k+16.
- height=0, category=200, and separately height=15, category=0 -> weight=0, overflow=0, latency still 16 cycles.
- Boundaries:
  - height=1, category=255 -> weight=255, overflow=0 (exact fit).
  - height=16, category=1 -> 256 -> weight=255, overflow=1.
- Start pulses at k+3 and k+16 during an active run -> ignored; single done; weight from the first operands. Operands changed at k+5 do not alter the result.
- Disruption cases:
  - enable dropped at k+8 -> IDLE next edge, weight=0, busy=0, no done.
  - rst_n pulsed low mid-SCALE -> outputs zero immediately; the next start completes normally with the correct value.
